pow_n_pipelined: RTL and testbench
==================================

Name: pow_n_pipelined

Overview:
- Parametrised successor to the single-cycle fifth-power block: computes x^N, truncated to width bits, through an elastic N-1 stage multiplier pipeline.
- Full valid/ready flow control on both sides, so downstream backpressure stalls the pipe without dropping data.
- Adds an in-flight item counter.
- Sits between a valid-qualified data source (key/counter stimulus on the board) and a display/consumer that may not accept every cycle.

Parameters:
- width, 12, data width of operand and result.
- n, 5, exponent; legal range 2..16; number of pipeline stages = n-1.
- cnt_w, $clog2(n), width of occupancy counter (localparam, not overridable).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- up_vld  input  1  upstream data valid.
- up_rdy  output  1  block can accept; transfer when up_vld & up_rdy at posedge clk.
- up_data  input  width  operand x.
- down_vld  output  1  result valid.
- down_rdy  input  1  consumer accepts; transfer when down_vld & down_rdy at posedge clk.
- down_data  output  width  x^n mod 2^width.
- down_ovf  output  1  result overflowed width (see Optional Feature).
- occupancy  output  cnt_w  number of valid stages (0..n-1).

Behaviour:
- Reset (async, rst=1): all stage valid bits 0; occupancy 0; down_vld 0; down_ovf 0. Data registers are don't-care but down_data reads 0 after reset. up_rdy is 1 whenever rst is 0 and the pipe is empty.
- Stage k (k=1..n-1) holds vld_k, x_k, acc_k = x^(k+1) mod 2^width.
  - Stage 1 loads x_1 = up_data and acc_1 = up_data*up_data.
  - Stage k>1 loads x_k = x_(k-1) and acc_k = acc_(k-1)*x_(k-1), truncated to width.
- Elastic handshake:
  - rdy_(n-1) = ~vld_(n-1) | down_rdy.
  - rdy_k = ~vld_k | rdy_(k+1).
  - up_rdy = rdy_1.
  - Stage k loads when rdy_k is 1. Its new vld_k equals the incoming valid (up_vld for k=1, vld_(k-1) otherwise).
  - When rdy_k is 0, stage k holds all of its contents.
  - The ready chain is combinational; no skid buffer.
- Outputs: down_vld = vld_(n-1); down_data = acc_(n-1).
- Latency: with down_rdy held 1, an item accepted at edge t appears on down_vld/down_data right after edge t+n-2 (n-1 register stages, counting the accepting edge). Default n=5: valid after the 4th edge.
- Throughput: 1 item/cycle when down_rdy = 1.
- Stall: down_rdy = 0 with a full pipe gives up_rdy = 0. Bubbles compress: an empty stage accepts even while later stages stall.
- Occupancy: registered; equals the number of set vld_k bits after each edge.
  - +1 on an up transfer.
  - -1 on a down transfer.
  - Unchanged when both occur in the same cycle.
  - Never exceeds n-1 and never underflows.
- down_vld must stay high and down_data stable until the down transfer completes (AXI-style rule).
- Reset mid-operation: all in-flight items are discarded immediately; no output transfer occurs in that cycle.
- Arithmetic: unsigned; products truncated to width every stage, so the result is exact modulo 2^width.

Optional Feature:
- Macro: POW_N_PIPELINED_OVERFLOW_EN.
- With the macro:
  - Each stage carries a sticky ovf_k bit.
  - Stage 1 sets it if the full 2*width product of x*x has nonzero upper width bits.
  - Stage k ORs in the same check on its own product.
  - down_ovf = ovf_(n-1), qualified by down_vld (0 when down_vld is 0).
- Without the macro: no ovf flops exist; down_ovf is tied to 0.

Test Plan:
1. Reset, then single item: up_data=3 with down_rdy=1 -> after 4 edges down_vld=1, down_data=243, down_ovf=0, occupancy=1; next cycle down_vld=0, occupancy=0.
2. Back-to-back: up_data=0,1,2,3,4 on consecutive cycles, down_rdy=1 -> outputs 0,1,32,243,1024 on 5 consecutive cycles; up_rdy stays 1.
3. Wrap/overflow: up_data=6 -> down_data=3680 (7776 mod 4096), down_ovf=1 with the macro, 0 without. up_data=7 -> 423, ovf=1. up_data=5 -> 3125, ovf=0.
4. Backpressure: stream 8 items with down_rdy=0 -> up_rdy drops after 4 accepts, occupancy=4, down_data held stable. Release down_rdy -> all 8 results arrive in order with no loss or duplication.
5. Bubble compression: load 2 items, stall 3 cycles, then up_vld pulses -> the empty stages accept while the head stage stalls; occupancy tracks exactly.
6. Async reset asserted with occupancy=3, between clock edges -> down_vld and occupancy clear immediately; no output transfer after reset release until a new item is sent.

Source files
------------

// File: rtl/pow_n_pipelined_if.sv
// Handshake bundle for pow_n_pipelined: upstream operand side, downstream result side,
// and the occupancy status.
interface pow_n_pipelined_if #(
   parameter int width = 12,
   parameter int n     = 5
);
   localparam int cnt_w = $clog2(n);

   // valid/ready: a beat moves at posedge clk when vld & rdy are both 1; a source holds
   // vld high and its data stable until that beat completes.
   logic             up_vld;
   logic             up_rdy;
   logic [width-1:0] up_data;
   logic             down_vld;
   logic             down_rdy;
   logic [width-1:0] down_data;
   logic             down_ovf;
   logic [cnt_w-1:0] occupancy;

   modport slave (
      input  up_vld, up_data, down_rdy,
      output up_rdy, down_vld, down_data, down_ovf, occupancy
   );

   modport master (
      output up_vld, up_data, down_rdy,
      input  up_rdy, down_vld, down_data, down_ovf, occupancy
   );
endinterface

// File: rtl/pow_n_pipelined.sv
// Elastic n-1 stage pipeline computing x^n mod 2^width with valid/ready on both sides.
// Optional sticky overflow tracking is enabled by defining POW_N_PIPELINED_OVERFLOW_EN.
module pow_n_pipelined #(
   parameter int width = 12,
   parameter int n     = 5
) (
   input logic           clk,
   input logic           rst,
   pow_n_pipelined_if.slave bus
);
   localparam int cnt_w = $clog2(n);

   logic [n-1:1]       vld_q;
   logic [width-1:0]   x_q   [1:n-1];
   logic [width-1:0]   acc_q [1:n-1];
   logic [2*width-1:0] prod  [1:n-1];
   logic [n-1:1]       rdy;
   logic [cnt_w-1:0]   occ_q;
   logic               up_xfer;
   logic               down_xfer;
   logic               unused_fold;

   // Ready ripples back from the consumer; a stage is ready if it or any later stage has a hole.
   always_comb begin : ready_chain
      logic r;
      r   = bus.down_rdy;
      rdy = '0;
      for (int k = n - 1; k >= 1; k--) begin
         r      = r | ~vld_q[k];
         rdy[k] = r;
      end
   end

   always_comb begin
      prod[1] = {{width{1'b0}}, bus.up_data} * {{width{1'b0}}, bus.up_data};
      for (int k = 2; k <= n - 1; k++) begin
         prod[k] = {{width{1'b0}}, acc_q[k-1]} * {{width{1'b0}}, x_q[k-1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int k = 1; k <= n - 1; k++) begin
            x_q[k]   <= '0;
            acc_q[k] <= '0;
         end
      end else begin
         if (rdy[1]) begin
            vld_q[1] <= bus.up_vld;
            x_q[1]   <= bus.up_data;
            acc_q[1] <= prod[1][width-1:0];
         end
         for (int k = 2; k <= n - 1; k++) begin
            if (rdy[k]) begin
               vld_q[k] <= vld_q[k-1];
               x_q[k]   <= x_q[k-1];
               acc_q[k] <= prod[k][width-1:0];
            end
         end
      end
   end

   assign up_xfer   = bus.up_vld & rdy[1];
   assign down_xfer = vld_q[n-1] & bus.down_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_q + cnt_w'(up_xfer) - cnt_w'(down_xfer);
      end
   end

`ifdef POW_N_PIPELINED_OVERFLOW_EN
   logic [n-1:1] ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= '0;
      end else begin
         if (rdy[1]) begin
            ovf_q[1] <= |prod[1][2*width-1:width];
         end
         for (int k = 2; k <= n - 1; k++) begin
            if (rdy[k]) begin
               ovf_q[k] <= ovf_q[k-1] | (|prod[k][2*width-1:width]);
            end
         end
      end
   end

   assign bus.down_ovf = vld_q[n-1] & ovf_q[n-1];
`else
   assign bus.down_ovf = 1'b0;
`endif

   // The last stage's operand copy and the product high halves have no consumer otherwise.
   always_comb begin
      unused_fold = ^x_q[n-1];
      for (int k = 1; k <= n - 1; k++) begin
         unused_fold = unused_fold ^ (^prod[k][2*width-1:width]);
      end
   end

   assign bus.up_rdy    = rdy[1];
   assign bus.down_vld  = vld_q[n-1];
   assign bus.down_data = acc_q[n-1];
   assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_pow_n_pipelined.sv
// Scoreboard bench for pow_n_pipelined (width=12, n=5): directed vectors with
// hand-computed fifth powers mod 4096; a negedge monitor pops and compares results.
module tb_pow_n_pipelined;
   localparam int width = 12;
   localparam int n     = 5;
`ifdef POW_N_PIPELINED_OVERFLOW_EN
   localparam bit ovf_en = 1'b1;
`else
   localparam bit ovf_en = 1'b0;
`endif

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   bit   sender_done;
   logic [width:0] exp_q[$];

   pow_n_pipelined_if #(.width(width), .n(n)) bus ();

   pow_n_pipelined #(.width(width), .n(n)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // driver: present one operand, push its expected result once the beat is accepted
   task automatic send(input logic [width-1:0] x, input logic [width-1:0] e, input bit f,
                       output int waited);
      bus.up_vld  = 1'b1;
      bus.up_data = x;
      waited      = 0;
      @(negedge clk);
      while (!bus.up_rdy && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      if (!bus.up_rdy) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: x=%0d never accepted", x);
         bus.up_vld = 1'b0;
      end else begin
         exp_q.push_back({ovf_en & f, e});
         @(posedge clk);
         #1;
         bus.up_vld = 1'b0;
      end
   endtask

   task automatic drain(input string nm);
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < 300) begin
         @(posedge clk);
         c++;
      end
      #1;
      check(nm, exp_q.size(), 0);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [width:0] e;
      if (!rst && bus.down_vld && bus.down_rdy) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_output: got data %0d expected no output", bus.down_data);
         end else begin
            e = exp_q.pop_front();
            if (bus.down_data !== e[width-1:0] || bus.down_ovf !== e[width]) begin
               fails++;
               $display("FAIL result: got data %0d ovf %0d expected data %0d ovf %0d",
                        bus.down_data, bus.down_ovf, e[width-1:0], e[width]);
            end
         end
      end
   end

   logic [width-1:0] bp_x [8] = '{12'd9, 12'd10, 12'd11, 12'd8, 12'd2, 12'd3, 12'd4, 12'd5};
   logic [width-1:0] bp_e [8] = '{12'd1705, 12'd1696, 12'd1307, 12'd0,
                                  12'd32, 12'd243, 12'd1024, 12'd3125};
   bit               bp_f [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      int w;
      int seen;
      tests       = 0;
      fails       = 0;
      sender_done = 1'b0;
      rst         = 1'b1;
      bus.up_vld  = 1'b0;
      bus.up_data = '0;
      bus.down_rdy = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_down_vld", bus.down_vld, 0);
      check("reset_down_data", bus.down_data, 0);
      check("reset_down_ovf", bus.down_ovf, 0);
      check("reset_occupancy", bus.occupancy, 0);
      check("reset_up_rdy", bus.up_rdy, 1);
      @(posedge clk);
      #1;

      // 1: single item latency
      send(12'd3, 12'd243, 1'b0, w);
      repeat (2) @(posedge clk);
      #1;
      check("t1_not_yet_valid", bus.down_vld, 0);
      @(posedge clk);
      #1;
      check("t1_valid_after_4_edges", bus.down_vld, 1);
      check("t1_data", bus.down_data, 243);
      check("t1_ovf", bus.down_ovf, 0);
      check("t1_occupancy", bus.occupancy, 1);
      @(posedge clk);
      #1;
      check("t1_vld_cleared", bus.down_vld, 0);
      check("t1_occ_cleared", bus.occupancy, 0);

      // 2: back-to-back, up_rdy must never drop
      seen = 0;
      send(12'd0, 12'd0, 1'b0, w);    seen += w;
      send(12'd1, 12'd1, 1'b0, w);    seen += w;
      send(12'd2, 12'd32, 1'b0, w);   seen += w;
      send(12'd3, 12'd243, 1'b0, w);  seen += w;
      send(12'd4, 12'd1024, 1'b0, w); seen += w;
      check("t2_no_wait_states", seen, 0);
      drain("t2_drain");

      // 3: wrap / overflow
      send(12'd6, 12'd3680, 1'b1, w);
      send(12'd7, 12'd423, 1'b1, w);
      send(12'd5, 12'd3125, 1'b0, w);
      send(12'd4095, 12'd4095, 1'b1, w);
      drain("t3_drain");

      // 4: backpressure with 8 items
      bus.down_rdy = 1'b0;
      fork
         begin
            int wb;
            for (int i = 0; i < 8; i++) send(bp_x[i], bp_e[i], bp_f[i], wb);
            sender_done = 1'b1;
         end
      join_none
      repeat (10) @(posedge clk);
      #1;
      check("t4_up_rdy_low", bus.up_rdy, 0);
      check("t4_occupancy_full", bus.occupancy, 4);
      check("t4_down_vld_held", bus.down_vld, 1);
      check("t4_head_data", bus.down_data, 1705);
      check("t4_head_ovf", bus.down_ovf, ovf_en);
      repeat (3) @(posedge clk);
      #1;
      check("t4_head_stable", bus.down_data, 1705);
      bus.down_rdy = 1'b1;
      seen = 0;
      while (!sender_done && seen < 300) begin
         @(posedge clk);
         seen++;
      end
      check("t4_sender_done", sender_done, 1);
      drain("t4_drain");
      repeat (3) @(posedge clk);
      #1;
      check("t4_no_duplicate", bus.down_vld, 0);
      check("t4_occ_empty", bus.occupancy, 0);

      // 5: bubble compression
      bus.down_rdy = 1'b0;
      send(12'd5, 12'd3125, 1'b0, w);
      send(12'd6, 12'd3680, 1'b1, w);
      repeat (3) @(posedge clk);
      #1;
      check("t5_occ_two", bus.occupancy, 2);
      send(12'd7, 12'd423, 1'b1, w);
      check("t5_bubble_accept_c", w, 0);
      check("t5_occ_three", bus.occupancy, 3);
      @(posedge clk);
      #1;
      send(12'd4095, 12'd4095, 1'b1, w);
      check("t5_bubble_accept_d", w, 0);
      check("t5_occ_four", bus.occupancy, 4);
      check("t5_full_up_rdy", bus.up_rdy, 0);
      bus.down_rdy = 1'b1;
      drain("t5_drain");

      // 6: async reset mid-operation
      bus.down_rdy = 1'b0;
      send(12'd2, 12'd32, 1'b0, w);
      send(12'd3, 12'd243, 1'b0, w);
      send(12'd4, 12'd1024, 1'b0, w);
      check("t6_occ_three", bus.occupancy, 3);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_vld", bus.down_vld, 0);
      check("t6_async_occ", bus.occupancy, 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      bus.down_rdy = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.down_vld) seen++;
      end
      check("t6_no_output_after_reset", seen, 0);
      @(posedge clk);
      #1;
      send(12'd3, 12'd243, 1'b0, w);
      drain("t6_recover_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
